regfile_wb_arbiter: RTL and testbench

//   Shares the single regfile write port between two writeback sources: the execute path (ex) and
//   the AXI load-return path (ld). Also holds a load scoreboard: a busy bit per GPR with an outstanding

---
 rtl/regfile_wb_arbiter_if.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the EXE/LSU writeback sources, decode and the regfile write port.
// The arbiter sits on the slave side; the master side is driven by the EXE/LSU/decode logic.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_addr;
    logic [XLEN-1:0] ex_data;

    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_addr;
    logic [XLEN-1:0] ld_data;

    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic            iss_ready;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            hazard;

    logic            w_ena;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;
    logic [31:0]     busy_o;

    modport master (
        output ex_valid, ex_addr, ex_data,
        output ld_valid, ld_addr, ld_data,
        output iss_valid, iss_rd,
        output rs1_addr, rs2_addr,
        input  ex_ready, ld_ready, iss_ready, hazard,
        input  w_ena, w_addr, w_data, busy_o
    );

    modport slave (
        input  ex_valid, ex_addr, ex_data,
        input  ld_valid, ld_addr, ld_data,
        input  iss_valid, iss_rd,
        input  rs1_addr, rs2_addr,
        output ex_ready, ld_ready, iss_ready, hazard,
        output w_ena, w_addr, w_data, busy_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between execute and load-return writeback,
// and keeps a per-GPR load scoreboard for decode hazards and ex/ld write ordering.
module regfile_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int SCW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIM);

    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic [SCW-1:0]  starve_cnt;
    logic            w_ena_q;
    logic [4:0]      w_addr_q;
    logic [XLEN-1:0] w_data_q;

    logic ex_elig;
    logic ld_elig;
    logic grant_ex;
    logic grant_ld;
    logic iss_ok;
    logic iss_take;
    logic rs1_haz;
    logic rs2_haz;

    // Load return wins by default; ex only overrides once it has waited STARVE_LIM cycles.
    always_comb begin
        ld_elig  = bus.ld_valid;
        ex_elig  = bus.ex_valid & ~(busy[bus.ex_addr] & (bus.ex_addr != 5'd0));
        grant_ex = ex_elig & (~ld_elig | (starve_cnt == STARVE_MAX));
        grant_ld = ld_elig & ~grant_ex;
        iss_ok   = ~busy[bus.iss_rd] | (bus.iss_rd == 5'd0);
        iss_take = bus.iss_valid & iss_ok & (bus.iss_rd != 5'd0);
    end

    // A fresh issue to the same rd as a returning load must leave the bit set.
    always_comb begin
        busy_nxt = busy;
        if (grant_ld) begin
            busy_nxt[bus.ld_addr] = 1'b0;
        end
        if (iss_take) begin
            busy_nxt[bus.iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // The regfile read port is not bypassed, so a write in flight also counts as a hazard.
    always_comb begin
        rs1_haz = (bus.rs1_addr != 5'd0) &
                  (busy[bus.rs1_addr] | (w_ena_q & (w_addr_q == bus.rs1_addr)));
        rs2_haz = (bus.rs2_addr != 5'd0) &
                  (busy[bus.rs2_addr] | (w_ena_q & (w_addr_q == bus.rs2_addr)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            starve_cnt <= '0;
            w_ena_q    <= 1'b0;
            w_addr_q   <= 5'd0;
            w_data_q   <= '0;
        end else begin
            busy <= busy_nxt;
            if (grant_ex || !ex_elig) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + SCW'(1);
            end
            if (grant_ld) begin
                w_ena_q  <= (bus.ld_addr != 5'd0);
                w_addr_q <= bus.ld_addr;
                w_data_q <= bus.ld_data;
            end else if (grant_ex) begin
                w_ena_q  <= (bus.ex_addr != 5'd0);
                w_addr_q <= bus.ex_addr;
                w_data_q <= bus.ex_data;
            end else begin
                w_ena_q  <= 1'b0;
            end
        end
    end

    assign bus.ex_ready  = grant_ex;
    assign bus.ld_ready  = grant_ld;
    assign bus.iss_ready = iss_ok;
    assign bus.hazard    = rs1_haz | rs2_haz;
    assign bus.w_ena     = w_ena_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.busy_o    = busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus randomized traffic, all checked each cycle against a
// cycle-level behavioural model of the arbitration and load scoreboard rules.
module tb_regfile_wb_arbiter;
    localparam int XLEN       = 64;
    localparam int STARVE_LIM = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    regfile_wb_arbiter_if #(.XLEN(XLEN)) bus_if ();

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIM(STARVE_LIM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile as seen through the DUT's write port.
    logic [XLEN-1:0] rf [32];
    always @(posedge clk) begin
        if (bus_if.w_ena) rf[bus_if.w_addr] <= bus_if.w_data;
    end

    // Model state: outstanding-load set, ex wait count, expected write port contents.
    bit              m_busy [32];
    int              m_wait;
    bit              m_w_ena;
    logic [4:0]      m_w_addr;
    logic [XLEN-1:0] m_w_data;
    bit              n_busy [32];
    int              n_wait;
    bit              n_w_ena;
    logic [4:0]      n_w_addr;
    logic [XLEN-1:0] n_w_data;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                               input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_wait   = 0;
        m_w_ena  = 1'b0;
        m_w_addr = 5'd0;
        m_w_data = '0;
    endtask

    task automatic applyStimulus(input bit exv, input int exa, input logic [XLEN-1:0] exd,
                                 input bit ldv, input int lda, input logic [XLEN-1:0] ldd,
                                 input bit isv, input int isr, input int r1, input int r2);
        bus_if.ex_valid  = exv;
        bus_if.ex_addr   = 5'(exa);
        bus_if.ex_data   = exd;
        bus_if.ld_valid  = ldv;
        bus_if.ld_addr   = 5'(lda);
        bus_if.ld_data   = ldd;
        bus_if.iss_valid = isv;
        bus_if.iss_rd    = 5'(isr);
        bus_if.rs1_addr  = 5'(r1);
        bus_if.rs2_addr  = 5'(r2);
    endtask

    function automatic bit is_hazard(input logic [4:0] rs);
        return (rs != 0) && (m_busy[rs] || (m_w_ena && m_w_addr == rs));
    endfunction

    // At the falling edge: compare everything visible, then work out the next model state.
    task automatic checkCycle();
        bit ex_ok, ex_win, ld_win, iss_ok;
        logic [31:0] busy_vec;
        @(negedge clk);
        ex_ok  = bus_if.ex_valid && (bus_if.ex_addr == 0 || !m_busy[bus_if.ex_addr]);
        ex_win = ex_ok && (!bus_if.ld_valid || m_wait == STARVE_LIM);
        ld_win = bus_if.ld_valid && !ex_win;
        iss_ok = (bus_if.iss_rd == 0) || !m_busy[bus_if.iss_rd];
        foreach (m_busy[i]) busy_vec[i] = m_busy[i];
        checkOutput("ex_ready",  XLEN'(bus_if.ex_ready),  XLEN'(ex_win));
        checkOutput("ld_ready",  XLEN'(bus_if.ld_ready),  XLEN'(ld_win));
        checkOutput("iss_ready", XLEN'(bus_if.iss_ready), XLEN'(iss_ok));
        checkOutput("hazard",    XLEN'(bus_if.hazard),
                    XLEN'(is_hazard(bus_if.rs1_addr) || is_hazard(bus_if.rs2_addr)));
        checkOutput("w_ena",     XLEN'(bus_if.w_ena),     XLEN'(m_w_ena));
        checkOutput("w_addr",    XLEN'(bus_if.w_addr),    XLEN'(m_w_addr));
        checkOutput("w_data",    bus_if.w_data,           m_w_data);
        checkOutput("busy_o",    XLEN'(bus_if.busy_o),    XLEN'(busy_vec));

        n_busy   = m_busy;
        n_w_addr = m_w_addr;
        n_w_data = m_w_data;
        n_w_ena  = 1'b0;
        if (ld_win) begin
            n_w_ena  = (bus_if.ld_addr != 0);
            n_w_addr = bus_if.ld_addr;
            n_w_data = bus_if.ld_data;
            n_busy[bus_if.ld_addr] = 1'b0;
        end else if (ex_win) begin
            n_w_ena  = (bus_if.ex_addr != 0);
            n_w_addr = bus_if.ex_addr;
            n_w_data = bus_if.ex_data;
        end
        if (bus_if.iss_valid && iss_ok && bus_if.iss_rd != 0) n_busy[bus_if.iss_rd] = 1'b1;
        n_wait = (ex_ok && !ex_win) ? ((m_wait < STARVE_LIM) ? m_wait + 1 : STARVE_LIM) : 0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_busy   = n_busy;
        m_wait   = n_wait;
        m_w_ena  = n_w_ena;
        m_w_addr = n_w_addr;
        m_w_data = n_w_data;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
        resetModel();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_w_ena", XLEN'(bus_if.w_ena), '0);
        checkOutput("reset_busy",  XLEN'(bus_if.busy_o), '0);

        // ex only to x5
        applyStimulus(1, 5, 64'h1234, 0, 0, '0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t2_ex_ready", XLEN'(bus_if.ex_ready), 1);
        advance();
        applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t2_w_ena",  XLEN'(bus_if.w_ena), 1);
        checkOutput("t2_w_addr", XLEN'(bus_if.w_addr), 5);
        checkOutput("t2_w_data", bus_if.w_data, 64'h1234);
        advance();

        // Both requesting every cycle: ld for four, then one forced ex grant
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 10, XLEN'(k), 1, 11, XLEN'(100 + k), 0, 0, 0, 0);
            checkCycle();
            checkOutput("t3_ex_ready", XLEN'(bus_if.ex_ready), XLEN'(k % 5 == 4));
            checkOutput("t3_ld_ready", XLEN'(bus_if.ld_ready), XLEN'(k % 5 != 4));
            advance();
        end

        // Load outstanding on x7 holds back ex until the load has written
        applyStimulus(0, 0, '0, 0, 0, '0, 1, 7, 0, 0);
        checkCycle();
        checkOutput("t4_iss_ready", XLEN'(bus_if.iss_ready), 1);
        advance();
        applyStimulus(1, 7, 64'hE7E7, 0, 0, '0, 0, 0, 7, 0);
        checkCycle();
        checkOutput("t4_ex_blocked", XLEN'(bus_if.ex_ready), 0);
        checkOutput("t4_hazard",     XLEN'(bus_if.hazard), 1);
        checkOutput("t4_busy7",      XLEN'(bus_if.busy_o[7]), 1);
        advance();
        applyStimulus(1, 7, 64'hE7E7, 1, 7, 64'hD7D7, 0, 0, 7, 0);
        checkCycle();
        checkOutput("t4_ld_ready", XLEN'(bus_if.ld_ready), 1);
        checkOutput("t4_ex_wait",  XLEN'(bus_if.ex_ready), 0);
        advance();
        applyStimulus(1, 7, 64'hE7E7, 0, 0, '0, 0, 0, 7, 0);
        checkCycle();
        checkOutput("t4_ld_w_data", bus_if.w_data, 64'hD7D7);
        checkOutput("t4_busy7_clr", XLEN'(bus_if.busy_o[7]), 0);
        checkOutput("t4_ex_ready",  XLEN'(bus_if.ex_ready), 1);
        checkOutput("t4_wr_hazard", XLEN'(bus_if.hazard), 1);
        advance();
        applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t4_ex_w_data", bus_if.w_data, 64'hE7E7);
        advance();
        checkOutput("t4_rf7", rf[7], 64'hE7E7);

        // Issue and return to x9 in the same cycle leaves x9 busy
        applyStimulus(0, 0, '0, 1, 9, 64'h99, 1, 9, 0, 0);
        checkCycle();
        checkOutput("t5_iss_ready", XLEN'(bus_if.iss_ready), 1);
        checkOutput("t5_ld_ready",  XLEN'(bus_if.ld_ready), 1);
        advance();
        applyStimulus(0, 0, '0, 0, 0, '0, 1, 9, 0, 0);
        checkCycle();
        checkOutput("t5_busy9",     XLEN'(bus_if.busy_o[9]), 1);
        checkOutput("t5_iss_block", XLEN'(bus_if.iss_ready), 0);
        advance();

        // ex to x0 completes but never writes
        applyStimulus(1, 0, 64'hBAD, 0, 0, '0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t6_ex_ready", XLEN'(bus_if.ex_ready), 1);
        checkOutput("t6_hazard0",  XLEN'(bus_if.hazard), 0);
        advance();
        applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
        checkCycle();
        checkOutput("t6_w_ena", XLEN'(bus_if.w_ena), 0);
        advance();

        // Asynchronous reset while a write is being presented and x9 is busy
        applyStimulus(1, 12, 64'hC12, 0, 0, '0, 0, 0, 0, 0);
        checkCycle();
        advance();
        checkOutput("t1_pre_w_ena", XLEN'(bus_if.w_ena), 1);
        applyStimulus(1, 13, 64'hC13, 0, 0, '0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t1_w_ena", XLEN'(bus_if.w_ena), 0);
        checkOutput("t1_busy",  XLEN'(bus_if.busy_o), 0);
        resetModel();
        applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkCycle();
        checkOutput("t1_no_write", XLEN'(bus_if.w_ena), 0);
        advance();

        // Random traffic over a small register window to force collisions
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 7), {$urandom, $urandom},
                          $urandom_range(0, 9) < 4, $urandom_range(0, 7), {$urandom, $urandom},
                          $urandom_range(0, 9) < 3, $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7));
            checkCycle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
